// File: rtl/ddr_wr_burst_tx.sv
// ddr_wr_burst_tx: DDR4 write transmitter issuing ACT/WR commands and a registered BL8/BC4 DQ/DQS burst with preamble.
module ddr_wr_burst_tx #(
  parameter int TRCD  = 4,
  parameter int CWL   = 9,
  parameter int ROW_W = 15,
  parameter int COL_W = 10
)(
  input  logic             CK_t,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_bg,
  input  logic [1:0]       req_ba,
  input  logic [ROW_W-1:0] req_row,
  input  logic [COL_W-1:0] req_col,
  input  logic             req_bc4,
  input  logic [63:0]      req_data,
  input  logic             close_all,
  output logic             cs_n,
  output logic             act_n,
  output logic             RAS_n_A16,
  output logic             CAS_n_A15,
  output logic             WE_n_A14,
  output logic [1:0]       bg_addr,
  output logic [1:0]       ba_addr,
  output logic             A13,
  output logic             A12_BC_n,
  output logic             A11,
  output logic             A10_AP,
  output logic [9:0]       A9_A0,
  output logic [7:0]       dq,
  output logic             dq_oe,
  output logic             dqs_t,
  output logic             dqs_c,
  output logic             dqs_oe,
  output logic             wr_done
);
  localparam int TW = $clog2(TRCD + 1);
  localparam int CW = $clog2(CWL + 1);
  typedef enum logic [2:0] {IDLE, ACT, TRCD_WAIT, WR, CWL_WAIT, PRE, BURST, DONE} state_t;
  state_t state, state_d;
  logic [TW-1:0] tcnt, tcnt_d;
  logic [CW-1:0] ccnt, ccnt_d;
  logic [2:0] beat, beat_d;
  logic [1:0] bg_q, ba_q;
  logic [ROW_W-1:0] row_q;
  logic [COL_W-1:0] col_q;
  logic bc4_q;
  logic [63:0] data_q;
  logic [ROW_W+3:0] rec;
  logic rec_valid, hit, accept;
  logic [4:0] cmd_q, cmd_d;
  logic [3:0] bank_q, bank_d;
  logic [13:0] addr_q, addr_d;
  logic [7:0] dq_d;
  logic dq_oe_d, dqs_oe_d, dqs_t_d, done_d;
  assign req_ready = state == IDLE;
  assign accept = req_valid && req_ready;
  assign hit = rec_valid && !close_all && rec == {req_bg, req_ba, req_row};
  assign {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14} = cmd_q;
  assign {bg_addr, ba_addr} = bank_q;
  assign {A13, A12_BC_n, A11, A10_AP, A9_A0} = addr_q;
  always_comb begin
    state_d  = state;
    tcnt_d   = tcnt;
    ccnt_d   = ccnt;
    beat_d   = beat;
    cmd_d    = 5'b11111;
    bank_d   = 4'hF;
    addr_d   = '1;
    dq_d     = '0;
    dq_oe_d  = 1'b0;
    dqs_oe_d = 1'b0;
    dqs_t_d  = 1'b1;
    done_d   = 1'b0;
    case (state)
      IDLE: if (req_valid) state_d = hit ? WR : ACT;
      ACT: begin
        cmd_d   = {4'b0011, row_q[14]};
        bank_d  = {bg_q, ba_q};
        addr_d  = row_q[13:0];
        tcnt_d  = TW'(TRCD > 1 ? TRCD - 2 : 0);
        state_d = TRCD > 1 ? TRCD_WAIT : WR;
      end
      TRCD_WAIT: begin
        tcnt_d  = tcnt - 1'b1;
        state_d = tcnt == '0 ? WR : TRCD_WAIT;
      end
      WR: begin
        cmd_d   = 5'b01100;
        bank_d  = {bg_q, ba_q};
        addr_d  = {1'b1, ~bc4_q, 1'b1, 1'b0, 10'(col_q)};
        ccnt_d  = CW'(CWL > 2 ? CWL - 3 : 0);
        beat_d  = '0;
        state_d = CWL > 2 ? CWL_WAIT : PRE;
      end
      CWL_WAIT: begin
        ccnt_d  = ccnt - 1'b1;
        state_d = ccnt == '0 ? PRE : CWL_WAIT;
      end
      PRE: begin
        dqs_oe_d = 1'b1;
        dqs_t_d  = 1'b0;
        state_d  = BURST;
      end
      BURST: begin
        dq_oe_d  = 1'b1;
        dqs_oe_d = 1'b1;
        dq_d     = data_q[8*beat +: 8];
        dqs_t_d  = ~beat[0];
        state_d  = beat == (bc4_q ? 3'd3 : 3'd7) ? DONE : BURST;
        beat_d   = beat == (bc4_q ? 3'd3 : 3'd7) ? beat : beat + 3'd1;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CK_t or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      tcnt      <= '0;
      ccnt      <= '0;
      beat      <= '0;
      bg_q      <= '0;
      ba_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      bc4_q     <= 1'b0;
      data_q    <= '0;
      rec       <= '0;
      rec_valid <= 1'b0;
      cmd_q     <= 5'b11111;
      bank_q    <= 4'hF;
      addr_q    <= '1;
      dq        <= '0;
      dq_oe     <= 1'b0;
      dqs_oe    <= 1'b0;
      dqs_t     <= 1'b1;
      dqs_c     <= 1'b0;
      wr_done   <= 1'b0;
    end else begin
      state  <= state_d;
      tcnt   <= tcnt_d;
      ccnt   <= ccnt_d;
      beat   <= beat_d;
      cmd_q  <= cmd_d;
      bank_q <= bank_d;
      addr_q <= addr_d;
      dq     <= dq_d;
      dq_oe  <= dq_oe_d;
      dqs_oe <= dqs_oe_d;
      dqs_t  <= dqs_t_d;
      dqs_c  <= ~dqs_t_d;
      wr_done <= done_d;
      if (accept) begin
        bg_q   <= req_bg;
        ba_q   <= req_ba;
        row_q  <= req_row;
        col_q  <= req_col;
        bc4_q  <= req_bc4;
        data_q <= req_data;
      end
      if (close_all) rec_valid <= 1'b0;
      else if (state == ACT) begin
        rec       <= {bg_q, ba_q, row_q};
        rec_valid <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ddr_wr_burst_tx.sv
// tb_ddr_wr_burst_tx: scoreboard bench; stimulus pushes expected bus events, a negedge monitor pops and compares them.
module tb_ddr_wr_burst_tx;
  localparam int TRCD = 4;
  localparam int CWL  = 9;
  logic CK_t = 1'b0, reset_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_bc4 = 1'b0, close_all = 1'b0;
  logic [1:0] req_bg = '0, req_ba = '0;
  logic [14:0] req_row = '0;
  logic [9:0] req_col = '0;
  logic [63:0] req_data = '0;
  logic cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14, A13, A12_BC_n, A11, A10_AP;
  logic [1:0] bg_addr, ba_addr;
  logic [9:0] A9_A0;
  logic [7:0] dq;
  logic dq_oe, dqs_t, dqs_c, dqs_oe, wr_done;

  ddr_wr_burst_tx #(.TRCD(TRCD), .CWL(CWL), .ROW_W(15), .COL_W(10)) dut (
    .CK_t(CK_t), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .req_bc4(req_bc4), .req_data(req_data), .close_all(close_all),
    .cs_n(cs_n), .act_n(act_n), .RAS_n_A16(RAS_n_A16), .CAS_n_A15(CAS_n_A15), .WE_n_A14(WE_n_A14),
    .bg_addr(bg_addr), .ba_addr(ba_addr), .A13(A13), .A12_BC_n(A12_BC_n), .A11(A11), .A10_AP(A10_AP),
    .A9_A0(A9_A0), .dq(dq), .dq_oe(dq_oe), .dqs_t(dqs_t), .dqs_c(dqs_c), .dqs_oe(dqs_oe), .wr_done(wr_done)
  );

  always #5 CK_t = ~CK_t;

  typedef struct {int cyc; int kind; logic [31:0] val;} ev_t;
  ev_t sb[$];
  int cyc = 0, total = 0, bad = 0;
  always @(posedge CK_t) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h at cyc=%0d", name, got, want, cyc);
    end
  endtask

  always @(negedge CK_t) begin
    int k;
    logic [31:0] v;
    ev_t e;
    k = 0;
    v = '0;
    if (reset_n) begin
      if (!cs_n) begin
        k = act_n ? 2 : 1;
        v = act_n ? 32'({RAS_n_A16, CAS_n_A15, WE_n_A14, bg_addr, ba_addr, A12_BC_n, A10_AP, A9_A0})
                  : 32'({RAS_n_A16, CAS_n_A15, bg_addr, ba_addr, WE_n_A14, A13, A12_BC_n, A11, A10_AP, A9_A0});
      end else if (wr_done) k = 5;
      else if (dq_oe) begin
        k = 4;
        v = 32'({dqs_oe, dqs_t, dqs_c, dq});
      end else if (dqs_oe) begin
        k = 3;
        v = 32'({dqs_t, dqs_c});
      end
      if (k != 0) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event kind=%0d val=%h at cyc=%0d", k, v, cyc);
        end else begin
          e = sb.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_kind", k, e.kind);
          chk("ev_val", v, e.val);
        end
      end
    end
  end

  function automatic ev_t mk(input int c, input int k, input logic [31:0] v);
    ev_t e;
    e.cyc = c;
    e.kind = k;
    e.val = v;
    return e;
  endfunction

  // Call at a negedge with req_ready seen high: drives the request and queues its expected bus events.
  task automatic drive_push(input logic [1:0] bg, input logic [1:0] ba, input logic [14:0] row,
                            input logic [9:0] col, input logic bc4, input logic [63:0] d, input logic cl,
                            input bit act, input int nb_exp, output int w);
    int n, acc;
    n = bc4 ? 4 : 8;
    req_valid = 1'b1;
    req_bg = bg; req_ba = ba; req_row = row; req_col = col; req_bc4 = bc4; req_data = d; close_all = cl;
    acc = cyc + 1;
    w = act ? acc + 1 + TRCD : acc + 1;
    if (act) sb.push_back(mk(acc + 1, 1, 32'({2'b11, bg, ba, row})));
    sb.push_back(mk(w, 2, 32'({3'b100, bg, ba, ~bc4, 1'b0, col})));
    sb.push_back(mk(w + CWL - 1, 3, 32'b01));
    for (int k = 0; k < n && k < nb_exp; k++)
      sb.push_back(mk(w + CWL + k, 4, 32'({1'b1, k % 2 == 0, k % 2 != 0, d[8*k +: 8]})));
    if (nb_exp >= n) sb.push_back(mk(w + CWL + n, 5, 32'b0));
  endtask

  task automatic send(input logic [1:0] bg, input logic [1:0] ba, input logic [14:0] row,
                      input logic [9:0] col, input logic bc4, input logic [63:0] d, input logic cl,
                      input bit act, input int nb_exp, input bit hold, output int w);
    int t;
    t = 0;
    w = 0;
    @(negedge CK_t);
    while (!req_ready && t < 200) begin
      @(negedge CK_t);
      t++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL ready_timeout got=0 want=1 at cyc=%0d", cyc);
    end else begin
      drive_push(bg, ba, row, col, bc4, d, cl, act, nb_exp, w);
      @(posedge CK_t);
      #1;
      if (!hold) req_valid = 1'b0;
      close_all = 1'b0;
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 300) begin
      @(negedge CK_t);
      t++;
    end
    repeat (3) @(negedge CK_t);
    chk("drain_left", sb.size(), 0);
  endtask

  localparam logic [63:0] D1 = 64'h8877665544332211;
  localparam logic [63:0] DA = 64'h0102030405060708;
  localparam logic [63:0] DB = 64'hF0E0D0C0B0A09080;

  initial begin
    int w, t;
    repeat (3) @(negedge CK_t);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_cmd", {act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 4'hF);
    chk("rst_oe", {dq_oe, dqs_oe}, 2'b00);
    chk("rst_dqs", {dqs_t, dqs_c}, 2'b10);
    chk("rst_dq_done", {dq, wr_done}, 9'h0);
    reset_n = 1'b1;
    @(negedge CK_t);
    chk("rst_ready", req_ready, 1);
    // T1 page miss, BL8
    send(2'd1, 2'd2, 15'h1234, 10'h010, 1'b0, D1, 1'b0, 1, 8, 0, w);
    drain();
    // T2 page hit
    send(2'd1, 2'd2, 15'h1234, 10'h010, 1'b0, D1, 1'b0, 0, 8, 0, w);
    drain();
    // T3 BC4 to another row
    send(2'd1, 2'd2, 15'h0555, 10'h3F8, 1'b1, D1, 1'b0, 1, 8, 0, w);
    drain();
    // T4 would hit, but close_all in accept cycle forces ACT
    send(2'd1, 2'd2, 15'h0555, 10'h020, 1'b0, D1, 1'b1, 1, 8, 0, w);
    drain();
    // T5 reset at beat 3
    send(2'd3, 2'd0, 15'h0777, 10'h100, 1'b0, DA, 1'b0, 1, 3, 0, w);
    t = 0;
    do begin
      @(posedge CK_t);
      #1;
      t++;
    end while (cyc < w + CWL + 3 && t < 100);
    chk("t5_beat3_on", {dq_oe, dq}, {1'b1, DA[31:24]});
    reset_n = 1'b0;
    #1;
    chk("t5_oe_off", {dq_oe, dqs_oe}, 2'b00);
    chk("t5_nop", {cs_n, act_n, RAS_n_A16, CAS_n_A15, WE_n_A14}, 5'h1F);
    chk("t5_no_done", wr_done, 0);
    repeat (2) @(negedge CK_t);
    reset_n = 1'b1;
    drain();
    send(2'd3, 2'd0, 15'h0777, 10'h100, 1'b0, DA, 1'b0, 1, 8, 0, w);
    drain();
    // T6 held req_valid with churning inputs: only the latched write goes out
    send(2'd3, 2'd0, 15'h0777, 10'h004, 1'b0, DA, 1'b0, 0, 8, 1, w);
    t = 0;
    while (t < 100) begin
      @(negedge CK_t);
      t++;
      if (req_ready) break;
      req_data = {$urandom, $urandom};
      req_row = 15'($urandom);
      req_col = 10'($urandom);
    end
    chk("t6_ready_again", req_ready, 1);
    drive_push(2'd3, 2'd0, 15'h0777, 10'h008, 1'b1, DB, 1'b0, 0, 8, w);
    @(posedge CK_t);
    #1;
    req_valid = 1'b0;
    // close_all mid-write only clears the record
    @(negedge CK_t);
    close_all = 1'b1;
    @(negedge CK_t);
    close_all = 1'b0;
    drain();
    send(2'd3, 2'd0, 15'h0777, 10'h008, 1'b0, DB, 1'b0, 1, 8, 0, w);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
